// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding request at a time
// on a req/gnt/rvalid bus, and hands {pc, inst} with a valid flag to the if_id register.
module if_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic        discard_r;
  logic        deliver;

  assign ibus_req_o  = (state == S_REQ);
  assign ibus_addr_o = pc_r;

  // A response is kept only if it was not redirected away, either earlier or this cycle.
  assign deliver = (state == S_WAIT) & ibus_rvalid_i & ~discard_r & ~jump_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc_r      <= RESET_ADDR;
      pend_pc_r <= RESET_ADDR;
      discard_r <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (ibus_gnt_i) begin
            state <= S_WAIT;
            if (jump_i) begin
              pc_r      <= jump_addr_i;
              discard_r <= 1'b1;
            end else begin
              pend_pc_r <= pc_r;
              pc_r      <= pc_r + 32'd4;
            end
          end else if (jump_i) begin
            pc_r <= jump_addr_i;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            if (discard_r | jump_i) begin
              discard_r <= 1'b0;
              state     <= S_REQ;
              if (jump_i) pc_r <= jump_addr_i;
            end else begin
              state <= S_IDLE;
            end
          end else if (jump_i) begin
            pc_r      <= jump_addr_i;
            discard_r <= 1'b1;
          end
        end
        S_IDLE: begin
          if (jump_i) begin
            pc_r  <= jump_addr_i;
            state <= S_REQ;
          end else if (~inst_valid_o | ~stall_i) begin
            // The output slot is free or drains this cycle, so the next response has room.
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o         <= RESET_ADDR;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (jump_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (deliver) begin
      pc_o         <= pend_pc_r;
      inst_o       <= ibus_rdata_i;
      inst_valid_o <= 1'b1;
    end else if (inst_valid_o & ~stall_i) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs change on the falling edge, outputs are checked
// on the falling edge after the rising edge that updated them.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;

  if_fetch #(
    .RESET_ADDR(32'h0000_0000),
    .NOP_INST  (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .stall_i      (stall_i),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // One full fetch: REQ cycle with same-cycle grant, WAIT cycle with rvalid.
  // Returns at the start of the IDLE cycle in which the instruction is presented.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    check("fetch_req", {31'd0, ibus_req_o}, 32'd1);
    check("fetch_addr", ibus_addr_o, exp_addr);
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    ibus_gnt_i = 1'b0;
    check("wait_noreq", {31'd0, ibus_req_o}, 32'd0);
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = data;
    @(negedge clk);
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'd0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic valid);
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_inst"}, inst_o, inst);
    check({tag, "_valid"}, {31'd0, inst_valid_o}, {31'd0, valid});
  endtask

  initial begin
    rst_n = 1'b0; jump_i = 1'b0; jump_addr_i = 32'd0; stall_i = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_out("rst", 32'h0, NOP, 1'b0);
    check("rst_req", {31'd0, ibus_req_o}, 32'd1);
    rst_n = 1'b1;

    // 1: first fetch after reset, delivered in cycle 2, next request addr 4 in cycle 3
    fetch(32'h0, 32'h0010_0093);
    check_out("t1", 32'h0, 32'h0010_0093, 1'b1);
    check("t1_idle_noreq", {31'd0, ibus_req_o}, 32'd0);
    @(negedge clk);
    check_out("t1_consumed", 32'h0, NOP, 1'b0);

    // 2: back-to-back fetches, one valid pulse every third cycle
    fetch(32'h4, 32'h1111_0004);
    check_out("t2_i1", 32'h4, 32'h1111_0004, 1'b1);
    @(negedge clk);
    check_out("t2_gap1", 32'h4, NOP, 1'b0);
    fetch(32'h8, 32'h1111_0008);
    check_out("t2_i2", 32'h8, 32'h1111_0008, 1'b1);

    // 3: stall held 5 cycles while pc_o=8 is presented
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_out("t3_hold", 32'h8, 32'h1111_0008, 1'b1);
      check("t3_noreq", {31'd0, ibus_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    @(negedge clk);
    check_out("t3_consumed", 32'h8, NOP, 1'b0);
    check("t3_req", {31'd0, ibus_req_o}, 32'd1);
    check("t3_addr", ibus_addr_o, 32'hC);
    fetch(32'hC, 32'h1111_000C);
    check_out("t2_i3", 32'hC, 32'h1111_000C, 1'b1);
    @(negedge clk);

    // 4: redirect while waiting, late response discarded
    check("t4_addr", ibus_addr_o, 32'h10);
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    ibus_gnt_i = 1'b0;
    jump_i = 1'b1; jump_addr_i = 32'h0000_0100;
    @(negedge clk);
    jump_i = 1'b0;
    check("t4_wait_noreq", {31'd0, ibus_req_o}, 32'd0);
    @(negedge clk);
    ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;
    check_out("t4_dropped", 32'hC, NOP, 1'b0);
    fetch(32'h100, 32'h2222_0100);
    check_out("t4_deliver", 32'h100, 32'h2222_0100, 1'b1);

    // jump flushes a stalled valid output
    stall_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h0000_0200;
    @(negedge clk);
    stall_i = 1'b0; jump_i = 1'b0;
    check_out("flush", 32'h100, NOP, 1'b0);

    // 5a: jump together with grant
    check("t5a_addr", ibus_addr_o, 32'h200);
    ibus_gnt_i = 1'b1; jump_i = 1'b1; jump_addr_i = 32'h0000_0300;
    @(negedge clk);
    ibus_gnt_i = 1'b0; jump_i = 1'b0;
    check("t5a_wait_noreq", {31'd0, ibus_req_o}, 32'd0);
    ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0001;
    @(negedge clk);
    ibus_rvalid_i = 1'b0;
    check_out("t5a_dropped", 32'h100, NOP, 1'b0);
    check("t5a_req", {31'd0, ibus_req_o}, 32'd1);
    check("t5a_addr2", ibus_addr_o, 32'h300);

    // 5b: jump coincident with rvalid
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    ibus_gnt_i = 1'b0;
    ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0002;
    jump_i = 1'b1; jump_addr_i = 32'h0000_0400;
    @(negedge clk);
    ibus_rvalid_i = 1'b0; jump_i = 1'b0;
    check_out("t5b_dropped", 32'h100, NOP, 1'b0);
    fetch(32'h400, 32'h3333_0400);
    check_out("t5b_deliver", 32'h400, 32'h3333_0400, 1'b1);
    check("t5b_idle_noreq", {31'd0, ibus_req_o}, 32'd0);

    // 6: PC wrap
    jump_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    @(negedge clk);
    jump_i = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h4444_FFFC);
    check_out("t6_top", 32'hFFFF_FFFC, 32'h4444_FFFC, 1'b1);
    @(negedge clk);
    fetch(32'h0, 32'h4444_0000);
    check_out("t6_wrap", 32'h0, 32'h4444_0000, 1'b1);
    @(negedge clk);
    fetch(32'h4, 32'h4444_0004);
    check_out("t6_four", 32'h4, 32'h4444_0004, 1'b1);
    @(negedge clk);

    // reset asserted while waiting for a response takes effect immediately
    check("t6_addr8", ibus_addr_o, 32'h8);
    ibus_gnt_i = 1'b1;
    @(negedge clk);
    ibus_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_out("t6_rst", 32'h0, NOP, 1'b0);
    check("t6_rst_req", {31'd0, ibus_req_o}, 32'd1);
    check("t6_rst_addr", ibus_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // a stray rvalid while requesting is ignored
    ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0003;
    @(negedge clk);
    ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;
    check_out("t6_stray", 32'h0, NOP, 1'b0);
    fetch(32'h0, 32'h5555_0000);
    check_out("t6_after", 32'h0, 32'h5555_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
